// File: rtl/mux_rr_pkg.sv
// Shared types and constants for the 16-way round-robin mux scheduler.
package mux_rr_pkg;

  localparam int unsigned N_REQ = 16;
  localparam int unsigned SEL_W = 4;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StSettleW = 2'd1,
    StSample  = 2'd2,
    StHold    = 2'd3
  } state_e;

endpackage

// File: rtl/rr_pick16.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping over 16 sources.
module rr_pick16
  import mux_rr_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] winner,
  output logic             any
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [SEL_W-1:0]   offset;

  always_comb begin
    // Rotate so bit 0 of rot is source ptr, then take the lowest set bit.
    dbl    = {req, req} >> ptr;
    rot    = dbl[N_REQ-1:0];
    offset = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) offset = SEL_W'(i);
    end
    winner = ptr + offset;
    any    = |req;
  end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler sharing one mux_16x1 between 16 requesters.
// Optional transfer counter output xfer_cnt is enabled by defining MUX_RR_CNT_EN.
module mux_rr_sched
  import mux_rr_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             mux_bit,
  output logic [SEL_W-1:0] select,
  output logic [N_REQ-1:0] gnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic [SEL_W-1:0] out_idx
`ifdef MUX_RR_CNT_EN
  ,
  output logic [15:0]      xfer_cnt
`endif
);

  localparam logic [3:0] CntLoad = 4'(SETTLE - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] select_q, select_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             bit_q, bit_d;
  logic [SEL_W-1:0] idx_q, idx_d;

  logic [SEL_W-1:0] winner;
  logic             any;
  logic             handshake;

  rr_pick16 u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (winner),
    .any    (any)
  );

  assign handshake = valid_q && out_ready;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    select_d = select_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    bit_d    = bit_q;
    idx_d    = idx_q;
    unique case (state_q)
      StIdle: begin
        if (any) begin
          select_d         = winner;
          gnt_d            = '0;
          gnt_d[winner]    = 1'b1;
          cnt_d            = CntLoad;
          state_d          = StSettleW;
        end
      end
      StSettleW: begin
        if (cnt_q == 4'd0) state_d = StSample;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StSample: begin
        bit_d   = mux_bit;
        idx_d   = select_q;
        valid_d = 1'b1;
        state_d = StHold;
      end
      StHold: begin
        // select stays locked until the sample is taken downstream.
        if (handshake) begin
          valid_d = 1'b0;
          gnt_d   = '0;
          ptr_d   = select_q + SEL_W'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      select_q <= '0;
      gnt_q    <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      bit_q    <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      select_q <= select_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      bit_q    <= bit_d;
      idx_q    <= idx_d;
    end
  end

  assign select    = select_q;
  assign gnt       = gnt_q;
  assign out_valid = valid_q;
  assign out_bit   = bit_q;
  assign out_idx   = idx_q;

`ifdef MUX_RR_CNT_EN
  logic [15:0] xfer_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         xfer_cnt_q <= '0;
    else if (handshake) xfer_cnt_q <= xfer_cnt_q + 16'd1;
  end

  assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_mux_rr_sched.sv
// Self-checking bench for mux_rr_sched with a transaction-level round-robin model.
module tb_mux_rr_sched;

  localparam int unsigned SETTLE = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] req = '0;
  logic        mux_bit;
  logic [3:0]  select;
  logic [15:0] gnt;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_bit;
  logic [3:0]  out_idx;
  logic [15:0] data_in = '0;
`ifdef MUX_RR_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int ptr_m = 0;

  always #5 clk = ~clk;

  // The external mux_16x1.
  assign mux_bit = data_in[select];

  mux_rr_sched #(.SETTLE(SETTLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mux_bit   (mux_bit),
    .select    (select),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .out_idx   (out_idx)
`ifdef MUX_RR_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  // First requesting source at or after p, wrapping.
  function automatic int pick(input logic [15:0] r, input int p);
    for (int k = 0; k < 16; k++) begin
      if (r[(p + k) % 16]) return (p + k) % 16;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    req = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
  endtask

  task automatic wait_valid(input int budget, output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    while (cycles < budget && !ok) begin
      @(negedge clk);
      cycles++;
      if (out_valid) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    int cyc; bit ok;
    rst_n = 1'b0;
    req = 16'hFFFF;
    out_ready = 1'b1;
    data_in = 16'($urandom);
    repeat (3) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (gnt !== 16'h0) begin bad++; $display("FAIL reset_gnt got=%h want=0000", gnt); end
    total++; if (select !== 4'h0) begin bad++; $display("FAIL reset_select got=%0d want=0", select); end
    total++; if (out_idx !== 4'h0 || out_bit !== 1'b0) begin
      bad++; $display("FAIL reset_out got idx=%0d bit=%b want idx=0 bit=0", out_idx, out_bit);
    end
    rst_n = 1'b1;
    ptr_m = 0;
    wait_valid(20, cyc, ok);
    total++; if (!ok || cyc != SETTLE + 2) begin
      bad++; $display("FAIL reset_first_latency got ok=%b cycles=%0d want %0d", ok, cyc, SETTLE + 2);
    end
    total++; if (out_idx !== 4'd0) begin bad++; $display("FAIL reset_first_idx got=%0d want=0", out_idx); end
    req = '0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || gnt !== 16'h0) begin
      bad++; $display("FAIL reset_handshake got valid=%b gnt=%h want 0/0000", out_valid, gnt);
    end
  endtask

  task automatic test_single();
    int cyc; bit ok;
    apply_reset();
    data_in = 16'h09EE;
    out_ready = 1'b1;
    req = 16'h0004;
    @(negedge clk);
    total++; if (select !== 4'd2 || gnt !== 16'h0004) begin
      bad++; $display("FAIL single_grant got sel=%0d gnt=%h want 2/0004", select, gnt);
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=1 want=0"); end
    wait_valid(20, cyc, ok);
    total++; if (!ok || cyc != SETTLE + 1) begin
      bad++; $display("FAIL single_latency got ok=%b cycles=%0d want %0d", ok, cyc + 1, SETTLE + 2);
    end
    total++; if (out_bit !== 1'b1 || out_idx !== 4'd2) begin
      bad++; $display("FAIL single_sample got bit=%b idx=%0d want 1/2", out_bit, out_idx);
    end
    req = '0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || gnt !== 16'h0 || select !== 4'd2) begin
      bad++; $display("FAIL single_done got valid=%b gnt=%h sel=%0d want 0/0000/2", out_valid, gnt, select);
    end
  endtask

  task automatic test_round_robin();
    int cyc; bit ok;
    int exp_seq[5] = '{0, 8, 15, 0, 8};
    apply_reset();
    out_ready = 1'b1;
    req = 16'h8101;
    for (int i = 0; i < 5; i++) begin
      wait_valid(20, cyc, ok);
      total++; if (!ok || cyc != ((i == 0) ? SETTLE + 2 : SETTLE + 3)) begin
        bad++; $display("FAIL rr_period[%0d] got ok=%b cycles=%0d", i, ok, cyc);
      end
      total++; if (out_idx !== 4'(exp_seq[i]) || gnt !== (16'h1 << exp_seq[i])) begin
        bad++; $display("FAIL rr_idx[%0d] got idx=%0d gnt=%h want idx=%0d", i, out_idx, gnt, exp_seq[i]);
      end
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int cyc; bit ok;
    int exp_w;
    logic [15:0] r;
    logic exp_bit;
    apply_reset();
    out_ready = 1'b0;
    r = 16'($urandom);
    if (r == '0) r = 16'h0001;
    req = r;
    data_in = 16'($urandom);
    exp_w = pick(r, ptr_m);
    wait_valid(20, cyc, ok);
    exp_bit = data_in[exp_w];
    total++; if (!ok || out_idx !== 4'(exp_w) || out_bit !== exp_bit) begin
      bad++; $display("FAIL bp_sample got ok=%b idx=%0d bit=%b want idx=%0d bit=%b",
                      ok, out_idx, out_bit, exp_w, exp_bit);
    end
    req = '0;
    for (int i = 0; i < 5; i++) begin
      data_in = ~data_in;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_bit !== exp_bit || out_idx !== 4'(exp_w) || select !== 4'(exp_w)) begin
        bad++; $display("FAIL bp_hold[%0d] got v=%b bit=%b idx=%0d sel=%0d want 1/%b/%0d/%0d",
                        i, out_valid, out_bit, out_idx, select, exp_bit, exp_w, exp_w);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    ptr_m = (exp_w + 1) % 16;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release got valid=1 want=0"); end
    req = 16'hFFFF;
    exp_w = pick(16'hFFFF, ptr_m);
    wait_valid(20, cyc, ok);
    repeat (3) @(negedge clk);
    total++; if (!ok || out_valid !== 1'b1 || out_idx !== 4'(exp_w)) begin
      bad++; $display("FAIL bp_one_xfer got ok=%b valid=%b idx=%0d want 1/1/%0d", ok, out_valid, out_idx, exp_w);
    end
    req = '0;
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_drop_req();
    int cyc; bit ok;
    apply_reset();
    out_ready = 1'b1;
    data_in = 16'($urandom);
    req = 16'h0010;
    @(negedge clk);
    req = '0;
    wait_valid(20, cyc, ok);
    total++; if (!ok || out_idx !== 4'd4 || out_bit !== data_in[4]) begin
      bad++; $display("FAIL drop_req got ok=%b idx=%0d bit=%b want 1/4/%b", ok, out_idx, out_bit, data_in[4]);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b0 || gnt !== 16'h0) begin
        bad++; $display("FAIL drop_idle[%0d] got valid=%b gnt=%h want 0/0000", i, out_valid, gnt);
      end
    end
  endtask

  task automatic test_reset_hold();
    int cyc; bit ok;
    logic [15:0] r;
    apply_reset();
    out_ready = 1'b0;
    r = 16'($urandom) | 16'h8000;
    req = r;
    wait_valid(20, cyc, ok);
    rst_n = 1'b0;
    #1;
    total++; if (!ok || out_valid !== 1'b0 || gnt !== 16'h0 || select !== 4'h0) begin
      bad++; $display("FAIL rst_hold got ok=%b valid=%b gnt=%h sel=%0d want 1/0/0000/0", ok, out_valid, gnt, select);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
    req = 16'hFFFF;
    out_ready = 1'b1;
    wait_valid(20, cyc, ok);
    total++; if (!ok || out_idx !== 4'd0) begin
      bad++; $display("FAIL rst_hold_ptr got ok=%b idx=%0d want 1/0", ok, out_idx);
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int cyc; bit ok;
    int exp_w;
    int hold;
    logic [15:0] r;
    logic exp_bit;
    apply_reset();
    for (int t = 0; t < 40; t++) begin
      data_in = 16'($urandom);
      r = 16'($urandom) & 16'($urandom);
      if (r == '0) r = 16'h1 << $urandom_range(0, 15);
      req = r;
      exp_w = pick(r, ptr_m);
      @(negedge clk);
      total++; if (gnt !== (16'h1 << exp_w) || select !== 4'(exp_w)) begin
        bad++; $display("FAIL rand_grant[%0d] got gnt=%h sel=%0d want sel=%0d", t, gnt, select, exp_w);
      end
      cyc = 1;
      ok = 1'b0;
      while (cyc < 20 && !ok) begin
        req = 16'($urandom);
        @(negedge clk);
        cyc++;
        if (out_valid) ok = 1'b1;
      end
      exp_bit = data_in[exp_w];
      out_ready = 1'b0;
      req = '0;
      total++; if (!ok || cyc != SETTLE + 2 || out_idx !== 4'(exp_w) || out_bit !== exp_bit) begin
        bad++; $display("FAIL rand_xfer[%0d] got ok=%b cyc=%0d idx=%0d bit=%b want %0d/%0d/%b",
                        t, ok, cyc, out_idx, out_bit, SETTLE + 2, exp_w, exp_bit);
      end
      hold = $urandom_range(0, 3);
      for (int i = 0; i < hold; i++) begin
        data_in = 16'($urandom);
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || out_bit !== exp_bit) begin
          bad++; $display("FAIL rand_hold[%0d] got valid=%b bit=%b want 1/%b", t, out_valid, out_bit, exp_bit);
        end
      end
      out_ready = 1'b1;
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rand_done[%0d] got valid=1 want=0", t); end
      out_ready = 1'($urandom_range(0, 1));
      ptr_m = (exp_w + 1) % 16;
    end
  endtask

`ifdef MUX_RR_CNT_EN
  task automatic test_counter();
    int cyc; bit ok;
    apply_reset();
    out_ready = 1'b1;
    req = 16'hFFFF;
    for (int i = 0; i < 20; i++) wait_valid(20, cyc, ok);
    req = '0;
    @(negedge clk);
    total++; if (xfer_cnt !== 16'd20) begin bad++; $display("FAIL cnt_20 got=%0d want=20", xfer_cnt); end
    force dut.xfer_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.xfer_cnt_q;
    req = 16'h0001;
    wait_valid(20, cyc, ok);
    req = '0;
    @(negedge clk);
    total++; if (!ok || xfer_cnt !== 16'h0) begin bad++; $display("FAIL cnt_wrap got=%h want=0000", xfer_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_drop_req();
    test_reset_hold();
    test_random();
`ifdef MUX_RR_CNT_EN
    test_counter();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_rr_sched.md
Name: mux_rr_sched

Overview:
Round-robin scheduler that shares one mux_16x1 between 16 requesters. It arbitrates the request lines, drives the mux select, and waits a programmable settle time. It then samples the mux output bit and presents it with its source index on a valid/ready output port. The block sits beside a mux_16x1 instance: select goes to the mux, and the mux data_out comes back as mux_bit.

Parameters:
N_REQ, 16, number of requesters; fixed at 16 to match mux_16x1
SEL_W, 4, select width; must equal log2(N_REQ)
SETTLE, 1, cycles select is held before sampling; legal range 1..15

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
req  input  16  request per source; level-sensitive
mux_bit  input  1  data_out of the external mux_16x1
select  output  4  mux select; registered
gnt  output  16  one-hot grant; registered; zero when idle
out_valid  output  1  sample available
out_ready  input  1  downstream accepts sample
out_bit  output  1  captured mux bit
out_idx  output  4  source index of out_bit

Behaviour:
- Reset (async assert, sync-released use of rst_n): state=IDLE, ptr=0, select=0, gnt=0, out_valid=0, out_bit=0, out_idx=0, settle counter=0.
- FSM states: IDLE, SETTLE_W, SAMPLE, HOLD.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the first set bit at index ptr, ptr+1, ..., wrapping modulo 16.
  - Register select=winner and gnt=1<<winner, load the counter with SETTLE-1, and go to SETTLE_W.
- SETTLE_W: decrement the counter; when it is 0, go to SAMPLE. Total dwell is SETTLE cycles.
- SAMPLE (one cycle):
  - Set out_bit<=mux_bit, out_idx<=select, out_valid<=1.
  - Go to HOLD.
- HOLD:
  - out_valid, out_bit, out_idx, select and gnt are held stable.
  - When out_valid && out_ready: set out_valid<=0, gnt<=0, ptr<=select+1 (4-bit wrap, so 15 goes to 0), and go to IDLE.
  - select keeps its last value while in IDLE.
- Latency and throughput:
  - req to out_valid rising takes SETTLE+2 cycles (IDLE decision edge, SETTLE cycles, SAMPLE edge).
  - Minimum period per transfer is SETTLE+3 cycles when out_ready is tied high.
- Boundary conditions:
  - A granted requester dropping req mid-transaction does not abort; the transfer completes.
  - New req bits arriving mid-transaction are considered only at the next IDLE.
  - All 16 req high: grants rotate 0,1,...,15,0 with no starvation.
  - A single persistent req: it is re-granted every transfer.
  - out_ready high while out_valid is low has no effect.
  - Reset mid-transaction returns to reset values immediately; the pending sample is lost.
- Grant lock: select never changes between leaving IDLE and the handshake.

Optional Feature:
MUX_RR_CNT_EN
- Defined: adds output xfer_cnt[15:0].
  - Reset value 0.
  - Increments by 1 on every out_valid&&out_ready handshake.
  - Wraps from 0xFFFF to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package mux_rr_pkg:
  - state enum (IDLE=2'd0, SETTLE_W=2'd1, SAMPLE=2'd2, HOLD=2'd3).
  - constants N_REQ=16 and SEL_W=4.
- One natural sub-module, rr_pick16: purely combinational, taking req[15:0] and ptr[3:0] and returning winner[3:0] and any.
  - Implemented as a double-width rotate plus priority encode.
  - Reusable by other arbiters in the codebase.

Test Plan:
- Reset: hold rst_n=0 with req=16'hFFFF. Require out_valid=0, gnt=0, select=0. After release, first grant=idx 0.
- Single request, SETTLE=1, out_ready=1, mux_16x1 data_in=16'h09EE:
  - req=16'h0004 gives select=2 and gnt=16'h0004.
  - out_valid rises 3 cycles after req.
  - out_bit=1 (bit2 of 09EE), out_idx=2.
- Round-robin: req=16'h8101 held, out_ready=1. Required out_idx sequence is 0,8,15,0,8. After idx 15, ptr wraps to 0.
- Backpressure:
  - With out_ready=0 for 5 cycles after out_valid, out_valid, out_bit, out_idx and select stay constant.
  - Changing data_in meanwhile does not alter out_bit.
  - Raising out_ready completes exactly one transfer.
- Mid-operation events:
  - Drop granted req during SETTLE_W: the transfer still completes.
  - Assert rst_n=0 during HOLD: out_valid=0 and gnt=0 immediately; after release, ptr=0.
- MUX_RR_CNT_EN defined: 20 handshakes give xfer_cnt=20. Forcing the counter to 16'hFFFF then one handshake gives 0.
